store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 34 +++
 rtl/stbuf_match.sv | 36 +++
 rtl/store_buffer.sv | 158 +++++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared MemWrite/MemRead size codes, byte-span constants and entry type.
// Mirrors the ctrl_encode_def definitions: none 2'b00, word 2'b01, halfword 2'b10, byte 2'b11.
// Optional forwarding is enabled by defining STBUF_FWD_EN.
package store_buffer_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_WORD = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_BYTE = 2'b11;

    localparam logic [2:0] SPAN_NONE = 3'd0;
    localparam logic [2:0] SPAN_BYTE = 3'd1;
    localparam logic [2:0] SPAN_HALF = 3'd2;
    localparam logic [2:0] SPAN_WORD = 3'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } sb_entry_t;

    function automatic logic [2:0] span_of(input logic [1:0] sz);
        return sz == MEM_WORD ? SPAN_WORD :
               sz == MEM_HALF ? SPAN_HALF :
               sz == MEM_BYTE ? SPAN_BYTE : SPAN_NONE;
    endfunction

    // Low bytes of a store's data for a load of size sz at the same address, zero-extended.
    function automatic logic [31:0] low_bytes(input logic [31:0] d, input logic [1:0] sz);
        return sz == MEM_BYTE ? {24'b0, d[7:0]} :
               sz == MEM_HALF ? {16'b0, d[15:0]} : d;
    endfunction

endpackage

// File: rtl/stbuf_match.sv
// stbuf_match: overlap / exact-match comparator between one buffered store and the load probe.
// Ports: valid_i entry occupied; e_addr_i/e_size_i entry; ld_addr_i/ld_size_i probe;
//        overlap_o byte ranges intersect; exact_o (only with STBUF_FWD_EN) forwardable match.
module stbuf_match
    import store_buffer_pkg::*;
(
    input  logic        valid_i,
    input  logic [31:0] e_addr_i,
    input  logic [1:0]  e_size_i,
    input  logic [31:0] ld_addr_i,
    input  logic [1:0]  ld_size_i,
    output logic        overlap_o
`ifdef STBUF_FWD_EN
    ,
    output logic        exact_o
`endif
);

    logic [2:0]  e_span, l_span;
    logic [32:0] e_lo, e_hi, l_lo, l_hi;

    assign e_span = span_of(e_size_i);
    assign l_span = span_of(ld_size_i);
    // 33-bit ends so a span reaching past 0xFFFFFFFF does not wrap to low addresses
    assign e_lo = {1'b0, e_addr_i};
    assign e_hi = e_lo + 33'(e_span);
    assign l_lo = {1'b0, ld_addr_i};
    assign l_hi = l_lo + 33'(l_span);

    assign overlap_o = valid_i && e_span != SPAN_NONE && l_span != SPAN_NONE && e_lo < l_hi && l_lo < e_hi;

`ifdef STBUF_FWD_EN
    assign exact_o = overlap_o && e_addr_i == ld_addr_i && e_span >= l_span;
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order CPU store FIFO draining into data memory, with load overlap detection.
// Ports: clk/rst (async, active-high); st_valid/st_addr/st_data/st_size/st_ready store input;
//        ld_addr/ld_size probe -> ld_hit/ld_data/ld_stall; drain_en memory free;
//        mem_addr/mem_wdata/mem_write registered memory write; empty/count occupancy.
// Define STBUF_FWD_EN to build store-to-load forwarding; otherwise any overlap stalls.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_ready,
    input  logic [31:0]              ld_addr,
    input  logic [1:0]               ld_size,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    output logic                     ld_stall,
    input  logic                     drain_en,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [1:0]               mem_write,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    sb_entry_t   buf_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]    mem_write_q, mem_write_d;
    logic          full, push, drain;
    logic [DEPTH-1:0] vld, ovl;
    logic          mem_ovl, any_ovl;

    assign full     = count_q == (AW+1)'(DEPTH);
    assign st_ready = !full;
    assign empty    = count_q == '0;
    assign count    = count_q;
    // st_ready ignores a same-cycle drain, so a full buffer never pushes
    assign push     = st_valid && st_ready && st_size != MEM_NONE;
    assign drain    = drain_en && !empty;

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;

    always_comb begin
        head_d      = drain ? head_q + 1'b1 : head_q;
        tail_d      = push ? tail_q + 1'b1 : tail_q;
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(drain);
        mem_addr_d  = drain ? buf_q[head_q].addr : mem_addr_q;
        mem_wdata_d = drain ? buf_q[head_q].data : mem_wdata_q;
        mem_write_d = drain ? buf_q[head_q].size : MEM_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= MEM_NONE;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (push)
            buf_q[tail_q] <= '{addr: st_addr, data: st_data, size: st_size};
    end

`ifdef STBUF_FWD_EN
    logic [DEPTH-1:0] ext;
    logic             mem_ext;
`endif

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_m
            logic [AW-1:0] rel;
            // slot is occupied when its distance from head is below count
            assign rel    = AW'(i) - head_q;
            assign vld[i] = {1'b0, rel} < count_q;
            stbuf_match u_match (
                .valid_i   (vld[i]),
                .e_addr_i  (buf_q[i].addr),
                .e_size_i  (buf_q[i].size),
                .ld_addr_i (ld_addr),
                .ld_size_i (ld_size),
                .overlap_o (ovl[i])
`ifdef STBUF_FWD_EN
                ,
                .exact_o   (ext[i])
`endif
            );
        end
    endgenerate

    // The in-flight memory write is older than every buffered entry but not yet in memory
    stbuf_match u_match_mem (
        .valid_i   (mem_write_q != MEM_NONE),
        .e_addr_i  (mem_addr_q),
        .e_size_i  (mem_write_q),
        .ld_addr_i (ld_addr),
        .ld_size_i (ld_size),
        .overlap_o (mem_ovl)
`ifdef STBUF_FWD_EN
        ,
        .exact_o   (mem_ext)
`endif
    );

    assign any_ovl = mem_ovl | (|ovl);

`ifdef STBUF_FWD_EN
    logic          new_exact;
    logic [31:0]   new_data;
    logic [AW-1:0] slot;

    // Walk oldest to newest so the last overlapping entry decides hit versus stall
    always_comb begin
        new_exact = mem_ext;
        new_data  = mem_wdata_q;
        slot      = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + AW'(k);
            if (ovl[slot]) begin
                new_exact = ext[slot];
                new_data  = buf_q[slot].data;
            end
        end
    end

    assign ld_hit   = new_exact;
    assign ld_stall = any_ovl && !new_exact;
    assign ld_data  = new_exact ? low_bytes(new_data, ld_size) : '0;
`else
    assign ld_hit   = 1'b0;
    assign ld_data  = '0;
    assign ld_stall = any_ovl;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scoreboard bench for store_buffer (both STBUF_FWD_EN builds).
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   st_valid;
    logic [31:0]            st_addr, st_data;
    logic [1:0]             st_size;
    logic                   st_ready;
    logic [31:0]            ld_addr;
    logic [1:0]             ld_size;
    logic                   ld_hit, ld_stall;
    logic [31:0]            ld_data;
    logic                   drain_en;
    logic [31:0]            mem_addr, mem_wdata;
    logic [1:0]             mem_write;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_ready  (st_ready),
        .ld_addr   (ld_addr),
        .ld_size   (ld_size),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .ld_stall  (ld_stall),
        .drain_en  (drain_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    exp_t sb[$];
    int   mcount = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference occupancy: accepted stores are queued in order, discarded on reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            mcount <= 0;
        end else begin
            if (st_valid && st_size != 2'b00 && mcount < DEPTH)
                sb.push_back('{st_addr, st_data, st_size});
            mcount <= mcount + int'(st_valid && st_size != 2'b00 && mcount < DEPTH)
                             - int'(drain_en && mcount > 0);
        end
    end

    // Every cycle with a valid write must be the oldest outstanding store
    always @(negedge clk) begin
        if (!rst && mem_write !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("spurious_write", {30'b0, mem_write}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", mem_addr, e.a);
                chk("wr_data", mem_wdata, e.d);
                chk("wr_size", {30'b0, mem_write}, {30'b0, e.s});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic probe(input string tag, input logic [31:0] a, input logic [1:0] s,
                         input logic eh, input logic [31:0] ed, input logic es, input bit cd);
        ld_addr = a;
        ld_size = s;
        #1;
        chk({tag, "_hit"}, {31'b0, ld_hit}, {31'b0, eh});
        if (cd)
            chk({tag, "_data"}, ld_data, ed);
        chk({tag, "_stall"}, {31'b0, ld_stall}, {31'b0, es});
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b00;
        ld_addr = '0; ld_size = 2'b00; drain_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_mem_write", {30'b0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
        chk("rst_ld_stall", {31'b0, ld_stall}, 32'd0);
        rst = 1'b0;
        tick();

        // single store, drained one edge after drain_en rises
        put(32'h10, 32'hDEADBEEF, 2'b01);
        tick();
        st_valid = 1'b0;
        chk("one_count", {29'b0, count}, 32'd1);
        chk("one_empty", {31'b0, empty}, 32'd0);
        drain_en = 1'b1;
        tick();
        chk("one_mem_write", {30'b0, mem_write}, 32'd1);
        chk("one_mem_addr", mem_addr, 32'h10);
        chk("one_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("one_empty_after", {31'b0, empty}, 32'd1);
        drain_en = 1'b0;
        tick();
        chk("one_write_none", {30'b0, mem_write}, 32'd0);

        // size none is ignored
        put(32'h50, 32'h1, 2'b00);
        tick();
        st_valid = 1'b0;
        chk("none_ignored", {29'b0, count}, 32'd0);

        // fill to DEPTH, overflow push dropped, one drain frees a slot
        for (int i = 0; i < DEPTH; i++) begin
            put(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b01);
            tick();
        end
        chk("full_count", {29'b0, count}, 32'(DEPTH));
        chk("full_ready", {31'b0, st_ready}, 32'd0);
        put(32'h200, 32'hBAD, 2'b01);
        tick();
        chk("full_dropped", {29'b0, count}, 32'(DEPTH));
        st_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        chk("drain1_ready", {31'b0, st_ready}, 32'd1);
        chk("drain1_count", {29'b0, count}, 32'(DEPTH - 1));
        repeat (DEPTH - 1) tick();
        drain_en = 1'b0;
        tick();
        chk("full_drained", {31'b0, empty}, 32'd1);

        // load probes against buffered stores
        put(32'h20, 32'h11223344, 2'b01);
        tick();
        put(32'hFFFFFFFF, 32'hAB, 2'b11);
        tick();
        st_valid = 1'b0;
        probe("ld_b20", 32'h20, 2'b11, FWD, FWD ? 32'h44 : 32'h0, !FWD, 1'b1);
        probe("ld_b21", 32'h21, 2'b11, 1'b0, 32'h0, 1'b1, 1'b0);
        probe("ld_h20", 32'h20, 2'b10, FWD, FWD ? 32'h3344 : 32'h0, !FWD, 1'b1);
        probe("ld_w20", 32'h20, 2'b01, FWD, FWD ? 32'h11223344 : 32'h0, !FWD, 1'b1);
        probe("ld_w24", 32'h24, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
        probe("ld_none", 32'h20, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        probe("ld_wrap0", 32'h0, 2'b01, 1'b0, 32'h0, 1'b0, 1'b0);
        probe("ld_bff", 32'hFFFFFFFF, 2'b11, FWD, FWD ? 32'hAB : 32'h0, !FWD, 1'b1);
        probe("ld_wfc", 32'hFFFFFFFC, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
        probe("ld_w1e", 32'h1E, 2'b01, 1'b0, 32'h0, 1'b1, 1'b0);
        put(32'h20, 32'h55667788, 2'b01);
        tick();
        st_valid = 1'b0;
        probe("ld_newest", 32'h20, 2'b11, FWD, FWD ? 32'h88 : 32'h0, !FWD, 1'b1);
        probe("ld_h22", 32'h22, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0);
        ld_size = 2'b00;
        drain_en = 1'b1;
        repeat (3) tick();
        drain_en = 1'b0;
        tick();
        chk("fwd_drained", {31'b0, empty}, 32'd1);

        // write sitting in the mem_* register is still probed
        put(32'h40, 32'hCAFEF00D, 2'b01);
        tick();
        st_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        probe("ld_memreg", 32'h40, 2'b10, FWD, FWD ? 32'hF00D : 32'h0, !FWD, 1'b1);
        tick();
        chk("memreg_gone_hit", {31'b0, ld_hit}, 32'd0);
        chk("memreg_gone_stall", {31'b0, ld_stall}, 32'd0);
        ld_size = 2'b00;

        // simultaneous push and drain at count 2, order kept across pointer wrap
        put(32'h300, 32'd0, 2'b01);
        tick();
        put(32'h304, 32'd1, 2'b01);
        tick();
        chk("pd_count_start", {29'b0, count}, 32'd2);
        drain_en = 1'b1;
        for (int k = 2; k < 6; k++) begin
            put(32'h300 + 32'(4 * k), 32'(k), 2'b01);
            tick();
            chk("pd_count", {29'b0, count}, 32'd2);
        end
        st_valid = 1'b0;
        repeat (2) tick();
        drain_en = 1'b0;
        tick();
        chk("pd_empty", {31'b0, empty}, 32'd1);
        chk("pd_sb_empty", 32'(sb.size()), 32'd0);

        // reset with entries pending and a write in flight
        for (int k = 0; k < 3; k++) begin
            put(32'h400 + 32'(4 * k), 32'h70 + 32'(k), 2'b01);
            tick();
        end
        st_valid = 1'b0;
        drain_en = 1'b1;
        tick();
        chk("pre_rst_count", {29'b0, count}, 32'd2);
        chk("pre_rst_write", {30'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_empty", {31'b0, empty}, 32'd1);
        chk("mid_rst_write", {30'b0, mem_write}, 32'd0);
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_ready", {31'b0, st_ready}, 32'd1);
        chk("mid_rst_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_write", {30'b0, mem_write}, 32'd0);
        chk("post_rst_empty", {31'b0, empty}, 32'd1);
        drain_en = 1'b0;
        tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
